// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the UART TX arbiter and its request picker.
// Timeout default covers one 11-bit frame at 5208 clocks per bit plus slack.
package uart_tx_arbiter_pkg;

    localparam int unsigned UART_DATA_WIDTH  = 8;
    localparam int unsigned UART_FRAME_WIDTH = 11;
    localparam int unsigned RX_CLOCK_WIDTH   = 5208;
    localparam int unsigned UART_TX_TIMEOUT  = UART_FRAME_WIDTH * RX_CLOCK_WIDTH + 1024;
    localparam int unsigned UART_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_START,
        ARB_WAIT_ACK,
        ARB_WAIT_DONE
    } uart_arb_fsm_e;

    // Round-robin successor of index g among n requesters.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational request picker: first valid request found scanning upward from ptr,
// wrapping past NUM_REQ-1 to 0.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && valid[IdxW'(cand)]) begin
                any = 1'b1;
                idx = IdxW'(cand);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among NUM_REQ byte producers with a hung-core watchdog.
// Define UART_ARB_RR_EN for round-robin arbitration; otherwise index 0 has fixed priority.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TX_TIMEOUT = UART_TX_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*UART_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               tx_start,
    output logic [UART_DATA_WIDTH-1:0]         tx_byte,
    input  logic                               tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               arb_busy,
    output logic                               timeout_err,
    input  logic                               err_clr
);

    localparam int unsigned      IdxW     = $clog2(NUM_REQ);
    localparam int unsigned      WdogW    = $clog2(TX_TIMEOUT + 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TX_TIMEOUT - 1);

    uart_arb_fsm_e              state_q;
    logic                       tx_start_q;
    logic                       arb_busy_q;
    logic [UART_DATA_WIDTH-1:0] tx_byte_q;
    logic [IdxW-1:0]            grant_id_q;
    logic                       timeout_err_q;
    logic [WdogW-1:0]           wdog_q;

    logic [IdxW-1:0]            ptr;
    logic [NUM_REQ-1:0]         pick_grant;
    logic [IdxW-1:0]            pick_idx;
    logic                       pick_any;
    logic [UART_DATA_WIDTH-1:0] pick_byte;
    logic                       wdog_fire;

    uart_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .valid(req_valid),
        .ptr  (ptr),
        .grant(pick_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef UART_ARB_RR_EN
    logic [IdxW-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (state_q == ARB_IDLE && pick_any) begin
            ptr_q <= IdxW'(rr_next(32'(pick_idx), NUM_REQ));
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign pick_byte = req_data[pick_idx*UART_DATA_WIDTH +: UART_DATA_WIDTH];
    assign wdog_fire = (state_q == ARB_WAIT_ACK || state_q == ARB_WAIT_DONE) &&
                       (wdog_q == WdogLast);

    // Accept is offered only while idle; the picker's grant is already one-hot.
    assign req_ready = (state_q == ARB_IDLE) ? pick_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            tx_start_q    <= 1'b0;
            arb_busy_q    <= 1'b0;
            tx_byte_q     <= '0;
            grant_id_q    <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        tx_byte_q  <= pick_byte;
                        grant_id_q <= pick_idx;
                        tx_start_q <= 1'b1;
                        arb_busy_q <= 1'b1;
                        state_q    <= ARB_START;
                    end
                end
                ARB_START: begin
                    tx_start_q <= 1'b0;
                    wdog_q     <= '0;
                    state_q    <= ARB_WAIT_ACK;
                end
                ARB_WAIT_ACK: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (wdog_fire) begin
                        arb_busy_q <= 1'b0;
                        state_q    <= ARB_IDLE;
                    end else if (tx_busy) begin
                        state_q <= ARB_WAIT_DONE;
                    end
                end
                ARB_WAIT_DONE: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (wdog_fire || !tx_busy) begin
                        arb_busy_q <= 1'b0;
                        state_q    <= ARB_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    arb_busy_q <= 1'b0;
                    state_q    <= ARB_IDLE;
                end
            endcase

            // A watchdog hit in the same cycle as a clear leaves the flag set.
            if (wdog_fire) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign tx_start    = tx_start_q;
    assign arb_busy    = arb_busy_q;
    assign tx_byte     = tx_byte_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a transaction-level model.
// A second instance with a short timeout and a core that never answers exercises the watchdog.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int          NR      = NUM_REQ;
    localparam int unsigned IdxW    = $clog2(NUM_REQ);

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*UART_DATA_WIDTH-1:0] req_data;
    logic                               err_clr;

    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx_start;
    logic [UART_DATA_WIDTH-1:0] tx_byte;
    logic                       tx_busy;
    logic [IdxW-1:0]            grant_id;
    logic                       arb_busy;
    logic                       timeout_err;

    logic [NUM_REQ-1:0]         wd_req_ready;
    logic                       wd_tx_start;
    logic [UART_DATA_WIDTH-1:0] wd_tx_byte;
    logic                       wd_tx_busy;
    logic [IdxW-1:0]            wd_grant_id;
    logic                       wd_arb_busy;
    logic                       wd_timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .TX_TIMEOUT(32)
    ) dut_wd (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (wd_req_ready),
        .tx_start   (wd_tx_start),
        .tx_byte    (wd_tx_byte),
        .tx_busy    (wd_tx_busy),
        .grant_id   (wd_grant_id),
        .arb_busy   (wd_arb_busy),
        .timeout_err(wd_timeout_err),
        .err_clr    (err_clr)
    );

    // Core model: busy rises busy_delay cycles after the tx_start cycle, lasts busy_len cycles.
    int unsigned busy_delay = 1;
    int unsigned busy_len   = 4;
    int unsigned core_cnt;
    int unsigned core_len;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt <= 0;
            core_len <= 0;
        end else if (tx_start) begin
            core_cnt <= busy_delay - 1 + busy_len;
            core_len <= busy_len;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
    end

    assign tx_busy    = (core_cnt != 0) && (core_cnt <= core_len);
    assign wd_tx_busy = 1'b0;

    // Model state: pending mask, per-requester byte, round-robin pointer.
    logic [NUM_REQ-1:0]         pend;
    logic [UART_DATA_WIDTH-1:0] bytes [NUM_REQ];
    int                         mptr;
    int                         n_checks;
    int                         n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
        for (int k = 0; k < NR; k++) begin
            if (m[IdxW'((p + k) % NR)]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NR; i++) begin
            req_data[i*UART_DATA_WIDTH +: UART_DATA_WIDTH] = bytes[i];
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        pend    = '0;
        err_clr = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
        @(negedge clk);
    endtask

    // Waits for an accept, checks winner and the following start cycle; returns in the start cycle.
    task automatic expect_grant(input string tag, input bit keep, output int g);
        int                         exp_g;
        bit                         seen;
        logic [NUM_REQ-1:0]         oh;
        logic [UART_DATA_WIDTH-1:0] exp_byte;
        exp_g = pick(pend, mptr);
        g     = exp_g;
        seen  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (req_ready != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_seen"}, 32'(seen), 1);
        if (!seen || exp_g < 0) return;
        oh = '0;
        oh[IdxW'(exp_g)] = 1'b1;
        exp_byte = bytes[exp_g];
        check({tag, "_ready"}, 32'(req_ready), 32'(oh));
        check({tag, "_idle_at_accept"}, 32'(arb_busy), 0);
        @(negedge clk);
        if (keep) bytes[exp_g] = 8'($urandom);
        else pend[IdxW'(exp_g)] = 1'b0;
        drive();
        #1;
        check({tag, "_tx_start"}, 32'(tx_start), 1);
        check({tag, "_tx_byte"}, 32'(tx_byte), 32'(exp_byte));
        check({tag, "_grant_id"}, 32'(grant_id), exp_g);
        check({tag, "_no_ready"}, 32'(req_ready), 0);
`ifdef UART_ARB_RR_EN
        mptr = (exp_g + 1) % NR;
`endif
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (!arb_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_back_idle"}, 32'(ok), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: bench exceeded its time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int g;
        int n_ab;
        int bad;
        int n_wait;
        bit seen_busy;
        bit frame_done;
        int exp_order [5];
        logic [NUM_REQ-1:0] add;

        n_checks = 0;
        n_errors = 0;
        mptr     = 0;
        for (int i = 0; i < NR; i++) bytes[i] = '0;
        rst_n   = 1'b0;
        pend    = '0;
        err_clr = 1'b0;
        drive();

        // Reset values
        #12;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_arb_busy", 32'(arb_busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_wd_timeout_err", 32'(wd_timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 1
        for (int i = 0; i < NR; i++) bytes[i] = 8'($urandom);
        bytes[1] = 8'hA5;
        pend     = 4'b0010;
        drive();
        expect_grant("t1", 1'b0, g);
        @(negedge clk);
        #1;
        check("t1_start_one_cycle", 32'(tx_start), 0);
        wait_idle("t1");

        // All requesters streaming, 20-cycle frames
`ifdef UART_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        do_reset();
        busy_delay = 2;
        busy_len   = 20;
        for (int i = 0; i < NR; i++) bytes[i] = 8'($urandom);
        pend = '1;
        drive();
        for (int k = 0; k < 5; k++) begin
            expect_grant("t2", 1'b1, g);
            check("t2_order", 32'(grant_id), exp_order[k]);
        end
        pend = '0;
        drive();
        wait_idle("t2");

        // Full-length frame: busy 3 cycles after start, held 57288 cycles
        busy_delay = 3;
        busy_len   = 57288;
        bytes[0]   = 8'($urandom);
        bytes[1]   = 8'($urandom);
        pend       = 4'b0011;
        drive();
        expect_grant("t3", 1'b0, g);
        n_ab       = 1;
        bad        = 0;
        seen_busy  = 1'b0;
        frame_done = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk);
            #1;
            if (arb_busy) n_ab++;
            if (tx_busy) begin
                seen_busy = 1'b1;
                if (!arb_busy) bad++;
            end else if (seen_busy) begin
                frame_done = 1'b1;
                break;
            end
        end
        check("t3_frame_done", 32'(frame_done), 1);
        check("t3_arb_busy_held", bad, 0);
        check("t3_arb_busy_cycles", n_ab, busy_delay + busy_len + 1);
        busy_len = 5;
        @(negedge clk);
        #1;
        check("t3_next_accept_gap", 32'(req_ready != '0), 1);
        expect_grant("t3b", 1'b0, g);

        // Randomized traffic with occasional withdrawals
        for (int r = 0; r < 40; r++) begin
            add = NUM_REQ'($urandom);
            for (int i = 0; i < NR; i++) begin
                if (add[i] && !pend[i]) bytes[i] = 8'($urandom);
            end
            pend = pend | add;
            if (pend == '0) pend[IdxW'($urandom_range(0, NR - 1))] = 1'b1;
            busy_delay = $urandom_range(1, 3);
            busy_len   = $urandom_range(1, 8);
            drive();
            expect_grant("rnd", 1'b0, g);
            if ($urandom_range(0, 3) == 0) begin
                pend[IdxW'($urandom_range(0, NR - 1))] = 1'b0;
                drive();
            end
        end
        pend = '0;
        drive();
        wait_idle("rnd");

        // Ungranted requester raises then drops valid while the arbiter is busy
        busy_delay = 1;
        busy_len   = 10;
        bytes[0]   = 8'($urandom);
        pend       = 4'b0001;
        drive();
        expect_grant("t6", 1'b0, g);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (req_ready != '0 || tx_start) bad++;
            if (c == 3) begin
                pend[1] = 1'b1;
                drive();
            end else if (c == 5) begin
                pend[1] = 1'b0;
                drive();
            end
        end
        check("t6_no_spurious", bad, 0);
        check("t6_idle", 32'(arb_busy), 0);

        // Hung core on the short-timeout instance
        do_reset();
        bytes[2] = 8'($urandom);
        pend     = 4'b0100;
        drive();
        #1;
        check("t4_wd_ready", 32'(wd_req_ready), 32'(4'b0100));
        @(negedge clk);
        pend = '0;
        drive();
        #1;
        check("t4_wd_tx_start", 32'(wd_tx_start), 1);
        n_wait = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (wd_arb_busy) n_wait++;
            else break;
        end
        check("t4_wait_cycles", n_wait, 32);
        check("t4_err_set", 32'(wd_timeout_err), 1);
        check("t4_main_no_err", 32'(timeout_err), 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("t4_err_cleared", 32'(wd_timeout_err), 0);
        bytes[0] = 8'($urandom);
        pend     = 4'b0001;
        drive();
        #1;
        check("t4b_wd_ready", 32'(wd_req_ready), 1);
        @(negedge clk);
        pend = '0;
        drive();
        repeat (32) @(negedge clk);
        err_clr = 1'b1;
        #1;
        check("t4b_last_wait_cycle", 32'(wd_arb_busy), 1);
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("t4b_set_beats_clear", 32'(wd_timeout_err), 1);
        check("t4b_wd_idle", 32'(wd_arb_busy), 0);
        @(negedge clk);
        #1;
        check("t4b_err_sticky", 32'(wd_timeout_err), 1);

        // Asynchronous reset while waiting for the frame to finish
        do_reset();
        busy_delay = 1;
        busy_len   = 50;
        bytes[2]   = 8'h5A;
        pend       = 4'b0100;
        drive();
        expect_grant("t5", 1'b0, g);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (tx_busy) break;
        end
        repeat (5) @(negedge clk);
        #2;
        check("t5_busy_before_reset", 32'(arb_busy), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx_start", 32'(tx_start), 0);
        check("t5_rst_tx_byte", 32'(tx_byte), 0);
        check("t5_rst_grant_id", 32'(grant_id), 0);
        check("t5_rst_arb_busy", 32'(arb_busy), 0);
        check("t5_rst_req_ready", 32'(req_ready), 0);
        mptr = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        bytes[0] = 8'($urandom);
        bytes[3] = 8'($urandom);
        pend     = 4'b1001;
        drive();
        expect_grant("t5a", 1'b0, g);
        expect_grant("t5b", 1'b0, g);
        wait_idle("t5");
        check("end_main_no_err", 32'(timeout_err), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
